// File: rtl/dsdac_reg_pkg.sv
// Shared definitions for the delta-sigma DAC register-write path.
// Holds the receiver's register map (addresses and field positions) and
// the writer's state type. No ports.
package dsdac_reg_pkg;

  localparam int ADDR_BITS = 3;
  localparam int NUM_REGS  = 3;

  // Register addresses
  localparam logic [ADDR_BITS-1:0] REG_U     = 3'd0;
  localparam logic [ADDR_BITS-1:0] REG_CTRL  = 3'd1;
  localparam logic [ADDR_BITS-1:0] REG_PULSE = 3'd2;

  // CTRL register bit positions
  localparam int CTRL_RSHIFT_LSB   = 8;
  localparam int CTRL_RSHIFT_MSB   = 11;
  localparam int CTRL_RESET_LFSR   = 12;
  localparam int CTRL_FORCE_ERR    = 13;
  localparam int CTRL_DUAL_SLOPE   = 14;
  localparam int CTRL_DOUBLE_SLOPE = 15;

  // PULSE register fields
  localparam int PULSE_DIVIDER_LSB    = 0;
  localparam int PULSE_DIVIDER_MSB    = 7;
  localparam int PULSE_NOISE_MODE_LSB = 14;
  localparam int PULSE_NOISE_MODE_MSB = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LO_SETUP  = 3'd1,
    ST_LO_STROBE = 3'd2,
    ST_HI_SETUP  = 3'd3,
    ST_HI_STROBE = 3'd4
  } wr_state_e;

endpackage

// File: rtl/dsdac_reg_writer_sync2.sv
// Generic two-flop synchronizer for a single asynchronous input.
// Ports: clk, rst_n (async active-low), d (async in), q (synchronized out).
// RST_VAL sets the level both flops take during reset.
module dsdac_reg_writer_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dsdac_reg_writer.sv
// Host-side transmitter for the DAC byte-serial register-write interface.
// A 16-bit {addr, data} request is sent as two byte phases: the low byte
// is latched by the receiver on the data_part falling edge, the full word
// on the rising edge. In ack mode each strobe phase waits for the echo pin
// to mirror the strobe before its hold time starts.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_addr, req_data      register address and value
//   ack_mode                gate strobe phases on echo (sampled at accept)
//   data_out, addr_out      DAC data bus and address
//   data_part_out, echo_out strobe and echo probe (identical, idle high)
//   echo_in                 asynchronous echo return
//   busy, done, err         status; done/err are one-cycle pulses
//
// state        | meaning
// ST_IDLE      | waiting for a request, strobe high
// ST_LO_SETUP  | low byte on bus, strobe high, setup count
// ST_LO_STROBE | strobe low (receiver latches low byte), echo wait + hold
// ST_HI_SETUP  | high byte on bus, strobe low, setup count
// ST_HI_STROBE | strobe high (receiver writes word), echo wait + hold
module dsdac_reg_writer
  import dsdac_reg_pkg::*;
#(
  parameter int ADDR_BITS      = dsdac_reg_pkg::ADDR_BITS,
  parameter int SETUP_CYCLES   = 2,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_BITS       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [15:0]          req_data,
  input  logic                 ack_mode,
  output logic [7:0]           data_out,
  output logic [ADDR_BITS-1:0] addr_out,
  output logic                 data_part_out,
  output logic                 echo_out,
  input  logic                 echo_in,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [CNT_BITS-1:0] SETUP_LAST = CNT_BITS'(SETUP_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] HOLD_LAST  = CNT_BITS'(HOLD_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] TMO_LAST   = CNT_BITS'(TIMEOUT_CYCLES - 1);

  wr_state_e            state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 wait_q, wait_d;
  logic                 ack_q, ack_d;
  logic [7:0]           hi_q, hi_d;
  logic [7:0]           data_q, data_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 dp_q, dp_d;
  logic                 echo_q;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 echo_sync;
  logic                 echo_target;
  logic [CNT_BITS-1:0]  hold_cnt;

  dsdac_reg_writer_sync2 #(.RST_VAL(1'b1)) u_echo_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (echo_in),
    .q     (echo_sync)
  );

  function automatic logic [CNT_BITS-1:0] cnt_inc(input logic [CNT_BITS-1:0] c);
    return (c == '1) ? c : c + CNT_BITS'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    ack_d   = ack_q;
    hi_d    = hi_q;
    data_d  = data_q;
    addr_d  = addr_q;
    dp_d    = dp_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    // The strobe level the echo must reach in the current strobe phase.
    echo_target = (state_q == ST_HI_STROBE);
    // The cycle in which the echo first matches already counts as hold cycle 0.
    hold_cnt = wait_q ? '0 : cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          data_d  = req_data[7:0];
          hi_d    = req_data[15:8];
          addr_d  = req_addr;
          ack_d   = ack_mode;
          dp_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_LO_SETUP;
        end
      end
      ST_LO_SETUP, ST_HI_SETUP: begin
        if (cnt_q >= SETUP_LAST) begin
          cnt_d   = '0;
          wait_d  = ack_q;
          dp_d    = (state_q == ST_HI_SETUP);
          state_d = (state_q == ST_HI_SETUP) ? ST_HI_STROBE : ST_LO_STROBE;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end
      ST_LO_STROBE, ST_HI_STROBE: begin
        if (wait_q && (echo_sync != echo_target)) begin
          if (cnt_q >= TMO_LAST) begin
            err_d   = 1'b1;
            dp_d    = 1'b1;
            wait_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_inc(cnt_q);
          end
        end else begin
          wait_d = 1'b0;
          if (hold_cnt >= HOLD_LAST) begin
            cnt_d = '0;
            if (state_q == ST_LO_STROBE) begin
              data_d  = hi_q;
              state_d = ST_HI_SETUP;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_inc(hold_cnt);
          end
        end
      end
      default: begin
        dp_d    = 1'b1;
        wait_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wait_q  <= 1'b0;
      ack_q   <= 1'b0;
      hi_q    <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      dp_q    <= 1'b1;
      echo_q  <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      ack_q   <= ack_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      dp_q    <= dp_d;
      echo_q  <= dp_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready     = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign data_out      = data_q;
  assign addr_out      = addr_q;
  assign data_part_out = dp_q;
  assign echo_out      = echo_q;

endmodule

// File: tb/tb_dsdac_reg_writer.sv
module tb_dsdac_reg_writer;
  import dsdac_reg_pkg::*;

  localparam int S   = 2;
  localparam int H   = 4;
  localparam int TMO = 255;
  localparam int S2  = 1;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic rx_clk = 1'b0;
  logic rst_n = 1'b0;
  int   rx_ph;

  always #5 clk = ~clk;

  // Receiver clock: same rate, random phase never aligned with clk posedge.
  initial begin
    rx_ph = int'($urandom_range(1, 9));
    #(5 + rx_ph);
    forever begin
      rx_clk = 1'b1; #5;
      rx_clk = 1'b0; #5;
    end
  end

  // DUT 1: default timing
  logic        req_valid1 = 1'b0, ack_mode1 = 1'b0;
  logic [2:0]  req_addr1 = '0;
  logic [15:0] req_data1 = '0;
  logic        ready1, busy1, done1, err1, dpo1, echo_o1;
  logic [7:0]  data1;
  logic [2:0]  addr1;
  logic        echo_i1;
  int          echo_sel = 0;
  logic [2:0]  dly = 3'b111;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) dly <= 3'b111;
    else        dly <= {dly[1:0], dpo1};
  assign echo_i1 = (echo_sel == 1) ? dly[2] : 1'b1;

  dsdac_reg_writer u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(ready1),
    .req_addr(req_addr1), .req_data(req_data1), .ack_mode(ack_mode1),
    .data_out(data1), .addr_out(addr1), .data_part_out(dpo1),
    .echo_out(echo_o1), .echo_in(echo_i1), .busy(busy1), .done(done1), .err(err1)
  );

  // DUT 2: minimum setup
  logic        req_valid2 = 1'b0, ack_mode2 = 1'b0, echo_i2 = 1'b1;
  logic [2:0]  req_addr2 = '0;
  logic [15:0] req_data2 = '0;
  logic        ready2, busy2, done2, err2, dpo2, echo_o2;
  logic [7:0]  data2;
  logic [2:0]  addr2;

  dsdac_reg_writer #(.SETUP_CYCLES(S2), .HOLD_CYCLES(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(ready2),
    .req_addr(req_addr2), .req_data(req_data2), .ack_mode(ack_mode2),
    .data_out(data2), .addr_out(addr2), .data_part_out(dpo2),
    .echo_out(echo_o2), .echo_in(echo_i2), .busy(busy2), .done(done2), .err(err2)
  );

  // Behavioural receivers: 2-FF sync of the strobe plus edge detect, bus
  // sampled directly when the edge is seen.
  logic [15:0] rx1_reg [8];
  logic [15:0] rx2_reg [8];
  logic [7:0]  rx1_lo = '0, rx2_lo = '0;
  logic [2:0]  rx1_s = 3'b111, rx2_s = 3'b111;
  logic [15:0] exp_reg [8];

  initial for (int i = 0; i < 8; i++) begin
    rx1_reg[i] = '0; rx2_reg[i] = '0; exp_reg[i] = '0;
  end

  always @(posedge rx_clk) begin
    rx1_s <= {rx1_s[1:0], dpo1};
    if (rx1_s[2] && !rx1_s[1]) rx1_lo <= data1;
    if (!rx1_s[2] && rx1_s[1]) rx1_reg[addr1] <= {data1, rx1_lo};
    rx2_s <= {rx2_s[1:0], dpo2};
    if (rx2_s[2] && !rx2_s[1]) rx2_lo <= data2;
    if (!rx2_s[2] && rx2_s[1]) rx2_reg[addr2] <= {data2, rx2_lo};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] obs1();
    return {ready1, busy1, done1, err1, dpo1, echo_o1, addr1, data1};
  endfunction

  // Precondition: request driven and DUT idle, sampled #1 after an edge.
  task automatic xfer(input logic [2:0] a, input logic [15:0] d, input bit chain,
                      input logic [2:0] na, input logic [15:0] nd);
    int n;
    logic e_dp;
    logic [16:0] e;
    n = 2 * (S + H);
    @(posedge clk); #1;
    for (int k = 0; k <= n; k++) begin
      if (k == 0) begin
        req_valid1 = chain;
        if (chain) begin req_addr1 = na; req_data1 = nd; end
      end
      e_dp = (k < S) || (k >= 2 * S + H);
      e = {(k == n), (k < n), (k == n), 1'b0, e_dp, e_dp, a,
           (k < S + H) ? d[7:0] : d[15:8]};
      chk($sformatf("plain_a%0d_k%0d", a, k), 32'(obs1()), 32'(e));
      if (k < n) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    int kd, errs, dones, prev_dp;
    logic [2:0]  a;
    logic [15:0] d;

    repeat (3) @(posedge clk); #1;
    chk("reset_vals", 32'(obs1()), 32'({4'b0000, 1'b1, 1'b1, 3'b000, 8'h00}));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'({ready1, busy1}), 32'(2'b10));

    // single plain write
    req_addr1 = REG_U; req_data1 = 16'h8000; ack_mode1 = 1'b0; req_valid1 = 1'b1;
    exp_reg[0] = 16'h8000;
    xfer(REG_U, 16'h8000, 1'b0, '0, '0);
    repeat (3) @(posedge clk); #1;
    chk("rx_reg0", 32'(rx1_reg[0]), 32'(exp_reg[0]));

    // back-to-back with valid held
    req_addr1 = REG_CTRL; req_data1 = 16'h9007; req_valid1 = 1'b1;
    exp_reg[1] = 16'h9007; exp_reg[2] = 16'hC010;
    xfer(REG_CTRL, 16'h9007, 1'b1, REG_PULSE, 16'hC010);
    xfer(REG_PULSE, 16'hC010, 1'b0, '0, '0);
    repeat (3) @(posedge clk); #1;
    chk("rx_reg1", 32'(rx1_reg[1]), 32'(exp_reg[1]));
    chk("rx_reg2", 32'(rx1_reg[2]), 32'(exp_reg[2]));

    // ack mode, echo = strobe delayed 3 cycles
    echo_sel = 1;
    d = 16'($urandom);
    req_addr1 = REG_PULSE; req_data1 = d; ack_mode1 = 1'b1; req_valid1 = 1'b1;
    exp_reg[2] = d;
    @(posedge clk); #1;
    req_valid1 = 1'b0; ack_mode1 = 1'b0;
    kd = -1; errs = 0;
    for (int k = 0; k < 400; k++) begin
      if (err1) errs++;
      if (done1) begin kd = k; break; end
      @(posedge clk); #1;
    end
    chk("ack_done_cycle", 32'(kd), 32'(2 * (S + H) + 2 * (3 + 2)));
    chk("ack_no_err", 32'(errs), 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("ack_rx_reg2", 32'(rx1_reg[2]), 32'(exp_reg[2]));

    // ack mode, echo stuck high -> timeout in the low phase
    echo_sel = 0;
    req_addr1 = REG_CTRL; req_data1 = 16'($urandom); ack_mode1 = 1'b1; req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0; ack_mode1 = 1'b0;
    kd = -1; dones = 0; prev_dp = -1;
    for (int k = 0; k < 600; k++) begin
      if (done1) dones++;
      if (err1) begin kd = k; break; end
      prev_dp = int'(dpo1);
      @(posedge clk); #1;
    end
    chk("tmo_err_cycle", 32'(kd), 32'(S + TMO));
    chk("tmo_dp_before", 32'(prev_dp), 32'd0);
    chk("tmo_dp_restored", 32'({dpo1, echo_o1}), 32'(2'b11));
    @(posedge clk); #1;
    chk("tmo_ready_next", 32'({ready1, busy1, err1}), 32'(3'b100));
    repeat (5) begin
      if (done1) dones++;
      @(posedge clk); #1;
    end
    chk("tmo_no_done", 32'(dones), 32'd0);

    // async reset during HI_SETUP
    req_addr1 = REG_U; req_data1 = 16'h5AA5; req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    for (int k = 0; k < S + H; k++) begin @(posedge clk); #1; end
    chk("pre_reset_hi_setup", 32'({dpo1, data1}), 32'({1'b0, 8'h5A}));
    #2 rst_n = 1'b0;
    #1 chk("async_reset_vals", 32'(obs1()), 32'({4'b0000, 1'b1, 1'b1, 3'b000, 8'h00}));
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", 32'({ready1, busy1, dpo1}), 32'(3'b101));
    req_addr1 = REG_U; req_data1 = 16'h1234; req_valid1 = 1'b1;
    exp_reg[0] = 16'h1234;
    xfer(REG_U, 16'h1234, 1'b0, '0, '0);
    repeat (3) @(posedge clk); #1;
    chk("post_reset_rx_reg0", 32'(rx1_reg[0]), 32'(exp_reg[0]));

    // random writes on the minimum-setup instance
    for (int i = 0; i < 8; i++) exp_reg[i] = rx2_reg[i];
    for (int i = 0; i < 1000; i++) begin
      a = 3'($urandom_range(0, 7));
      d = 16'($urandom);
      exp_reg[a] = d;
      req_addr2 = a; req_data2 = d; req_valid2 = 1'b1;
      @(posedge clk); #1;
      req_valid2 = 1'b0;
      kd = 50;
      for (int k = 0; k < 50; k++) begin
        if (done2) begin kd = k; break; end
        @(posedge clk); #1;
      end
      chk($sformatf("rnd%0d_latency", i), 32'(kd), 32'(2 * (S2 + 4)));
      repeat (3) @(posedge clk); #1;
      chk($sformatf("rnd%0d_reg%0d", i, a), 32'(rx2_reg[a]), 32'(exp_reg[a]));
    end
    for (int i = 0; i < 8; i++)
      chk($sformatf("rnd_final_reg%0d", i), 32'(rx2_reg[i]), 32'(exp_reg[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
